// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state and grant encodings,
// default sizing, and a counter-width helper.
package dmem_arb_pkg;

  typedef enum logic {
    CORE_PRI  = 1'b0,
    EXT_BURST = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CORE = 2'd1,
    GNT_EXT  = 2'd2
  } grant_t;

  localparam int DEF_ADDR_W       = 10;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 8;
  localparam int DEF_MAX_BURST    = 4;

  // Bits needed to hold a counter that reaches max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle between the requesters (MEM-stage core port and
// external loader/debug port) and the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);

  // Core (MEM stage) side: byte address, stall-based flow control.
  logic              core_req;
  logic              core_we;
  logic [31:0]       core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;

  // External side: word address, valid/ready handshake, rvalid for reads.
  logic              ext_valid;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_ready;
  logic              ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_rdata, core_stall,
    output ext_valid, ext_we, ext_addr, ext_wdata,
    input  ext_ready, ext_rvalid, ext_rdata
  );

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_rdata, core_stall,
    input  ext_valid, ext_we, ext_addr, ext_wdata,
    output ext_ready, ext_rvalid, ext_rdata
  );

endinterface

// File: rtl/dmem_ram.sv
// Single-port data RAM with registered (1-cycle) read, read-before-write on
// the same address. Instantiated next to the arbiter, never inside it;
// contents start undefined and are loaded through the ports.
module dmem_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_array [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  // One access per enabled cycle: optional write plus registered read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_array[addr] <= wdata;
      end
      rdata_reg <= mem_array[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: one RAM access per cycle, core priority by default,
// with a starvation guard that forces bounded ext bursts while the pipeline
// is stalled. Grant is combinational from registered state and the current
// requests, so an uncontended core access adds no latency.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int MAX_BURST    = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     bus,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WAIT_W  = cnt_width(STARVE_LIMIT);
  localparam int BURST_W = cnt_width(MAX_BURST);

  arb_state_t         state_reg, state_next;
  logic [WAIT_W-1:0]  wait_cnt_reg;
  logic [BURST_W-1:0] burst_cnt_reg, burst_next;
  logic [BURST_W-1:0] burst_plus;
  logic               ext_rvalid_reg;
  logic               starved;
  grant_t             grant;
  logic [ADDR_W-1:0]  core_word;

  // Core address is a byte address; drop the byte offset and anything above
  // the RAM size so accesses wrap modulo the RAM depth.
  assign core_word  = bus.core_addr[ADDR_W+1:2];
  assign starved    = (wait_cnt_reg == WAIT_W'(STARVE_LIMIT));
  assign burst_plus = BURST_W'(burst_cnt_reg + 1);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.core_addr[31:ADDR_W+2], bus.core_addr[1:0]};

  // State, counters and ext read-valid; reset drops any in-flight ext read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= CORE_PRI;
      wait_cnt_reg   <= '0;
      burst_cnt_reg  <= '0;
      ext_rvalid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      burst_cnt_reg <= burst_next;
      if (!bus.ext_valid || grant == GNT_EXT) begin
        wait_cnt_reg <= '0;
      end else if (!starved) begin
        wait_cnt_reg <= WAIT_W'(wait_cnt_reg + 1);
      end
      ext_rvalid_reg <= (grant == GNT_EXT) && !bus.ext_we;
    end
  end

  // Grant selection and next state / burst count.
  always_comb begin
    state_next = state_reg;
    burst_next = burst_cnt_reg;
    grant      = GNT_NONE;
    case (state_reg)
      CORE_PRI: begin
        if (bus.ext_valid && starved) begin
          // Forced grant is the first of the burst; a one-grant burst
          // never leaves core priority.
          grant = GNT_EXT;
          if (MAX_BURST > 1) begin
            state_next = EXT_BURST;
            burst_next = BURST_W'(1);
          end else begin
            burst_next = '0;
          end
        end else if (bus.core_req) begin
          grant = GNT_CORE;
        end else if (bus.ext_valid) begin
          grant = GNT_EXT;
        end
      end
      EXT_BURST: begin
        if (bus.ext_valid) begin
          grant = GNT_EXT;
          if (burst_plus == BURST_W'(MAX_BURST)) begin
            state_next = CORE_PRI;
            burst_next = '0;
          end else begin
            burst_next = burst_plus;
          end
        end else begin
          // Ext went idle: burst ends now and the core gets this cycle.
          grant      = bus.core_req ? GNT_CORE : GNT_NONE;
          state_next = CORE_PRI;
          burst_next = '0;
        end
      end
      default: begin
        state_next = CORE_PRI;
        burst_next = '0;
      end
    endcase
    if (reset) begin
      grant = GNT_NONE;
    end
  end

  // RAM port mux and requester-facing outputs from the grant.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (grant)
      GNT_CORE: begin
        mem_en    = 1'b1;
        mem_we    = bus.core_we;
        mem_addr  = core_word;
        mem_wdata = bus.core_wdata;
      end
      GNT_EXT: begin
        mem_en    = 1'b1;
        mem_we    = bus.ext_we;
        mem_addr  = bus.ext_addr;
        mem_wdata = bus.ext_wdata;
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
    bus.ext_ready  = (grant == GNT_EXT);
    bus.core_stall = !reset && bus.core_req && (grant != GNT_CORE);
    bus.core_rdata = mem_rdata;
    bus.ext_rdata  = mem_rdata;
    bus.ext_rvalid = ext_rvalid_reg;
  end

endmodule
